axilm_wr_arb: RTL and testbench
===============================

# axilm_wr_arb

Round-robin arbiter that shares one AXI4-Lite write-master channel block among `N_REQ` local requesters. It accepts one write at a time and drives the channel's local interface (`USR_ENA`/`USR_WSTB`/`USR_ADDR`/`USR_WDATA`). It detects completion by monitoring the B-channel handshake and returns `USR_BRESP` to the requester that owns the transaction. It sits between the local bus fabric and the write-channel block, and has exactly one write outstanding at a time.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8.
- `ACLK` in 1 — clock, all logic on rising edge.
- `ARESET` in 1 — asynchronous, active-high reset.
- `REQ_VALID` in N_REQ — per-requester write request; held until accepted.
- `REQ_WSTB` in 4*N_REQ — byte strobes; requester i uses bits [4i+3:4i].
- `REQ_ADDR` in 32*N_REQ — write address; requester i uses bits [32i+31:32i].
- `REQ_WDATA` in 32*N_REQ — write data; requester i uses bits [32i+31:32i].
- `REQ_READY` out N_REQ — one-hot accept; combinational; high only in IDLE, for the winner.
- `REQ_DONE` out N_REQ — one-hot, one-cycle completion pulse, registered.
- `REQ_BRESP` out 2 — response; valid when any `REQ_DONE` bit is high, otherwise holds its last value.
- `BUSY` out 1 — high in every state except IDLE.
- `USR_ENA` out 1 — one-cycle start pulse to the channel block.
- `USR_WSTB` out 4 — latched strobes.
- `USR_ADDR` out 32 — latched address.
- `USR_WDATA` out 32 — latched data.
- `USR_BRESP` in 2 — channel's registered response; valid one cycle after the B handshake.
- `BVALID` in 1 — bus monitor tap.
- `BREADY` in 1 — bus monitor tap.

## Operation
- States:
  - IDLE, ISSUE, WAIT_RESP, RESP, plus LOCAL_DONE for writes with all strobes zero.
  - IDLE is the reset state.
- IDLE:
  - If any `REQ_VALID` bit is high, the winner is the first set bit searching upward from pointer `ptr`, wrapping modulo N_REQ.
  - `REQ_READY[winner]=1` in that same cycle.
  - On that edge the block latches the winner's WSTB, ADDR and WDATA into the `USR_*` registers and stores the winner index in `gnt`.
  - Next state: ISSUE if the latched strobe is non-zero, LOCAL_DONE if it is zero.
  - If no `REQ_VALID` bit is high, stay in IDLE.
- ISSUE: `USR_ENA=1` for exactly this cycle; next state WAIT_RESP.
- WAIT_RESP: stay until `BVALID & BREADY`; then go to RESP.
- RESP:
  - `REQ_DONE[gnt]=1`.
  - `REQ_BRESP` is loaded from `USR_BRESP`, which is now valid.
  - `ptr` becomes `gnt+1` mod N_REQ.
  - Next state IDLE.
- LOCAL_DONE:
  - Handles writes whose strobe is all zeros, which the channel block would ignore. Nothing is issued to the bus.
  - `REQ_DONE[gnt]=1`, `REQ_BRESP=OKAY`, `ptr` is advanced as in RESP.
  - Next state IDLE.
- Requests arriving while BUSY simply wait; `REQ_VALID` must stay high until `REQ_READY`.
- A requester may drop `REQ_VALID` before it is granted; that is legal and no transaction results.
- The B handshake is counted only in WAIT_RESP. A handshake seen in any other state is ignored.
- Reset, including mid-transaction:
  - State goes to IDLE and `ptr` to 0.
  - `USR_ENA`, `REQ_DONE`, `USR_WSTB`, `USR_ADDR`, `USR_WDATA` and `REQ_BRESP` all go to 0.
  - The channel block must be reset in the same cycle. No DONE is produced for the aborted write.

## Timing
- `REQ_READY` at cycle T (IDLE) → `USR_ENA` at T+1 → earliest B handshake at T+3 → RESP and `REQ_DONE` at T+4 (AWREADY, WREADY and BVALID all immediate).
- Zero-strobe write: `REQ_READY` at T → `REQ_DONE` at T+1.
- Back-to-back: the next `REQ_READY` is possible one cycle after `REQ_DONE`, i.e. RESP → IDLE takes one cycle.
- `USR_*` payload is stable from ISSUE until the next grant.

## Structure
- Shared package `axilm_pkg`:
  - State enum `arb_state_t` (3 bits).
  - BRESP constants: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
- Sub-module `rr_pick`:
  - Parameter N.
  - Inputs: `req` [N], `ptr` [$clog2(N)].
  - Outputs: one-hot `gnt` [N], index `idx`, `any`.
  - Purely combinational; `ptr` stays in the arbiter.

## Test plan
- Single request: requester 2 writes ADDR=0x0000_1000, WDATA=0xDEADBEEF, WSTB=0xF; slave responds OKAY.
  - `USR_ENA` pulses once with that payload; `REQ_DONE[2]` pulses one cycle after the B handshake; `REQ_BRESP=00`.
- All four `REQ_VALID` held high with instant-ready slave:
  - Grant order is 0,1,2,3,0.
  - Exactly one transaction is outstanding at a time, with one `REQ_DONE` per grant.
- Zero strobe: requester 1 with WSTB=0.
  - `REQ_DONE[1]` at T+1; `USR_ENA` never asserted; `REQ_BRESP=00`; no AW/W traffic.
- Slave returns SLVERR after a 5-cycle AWREADY stall and a 3-cycle BVALID delay:
  - `REQ_BRESP=10` with `REQ_DONE` on the correct requester.
  - `BUSY` is high throughout.
- Reset asserted during WAIT_RESP:
  - All outputs go to 0 and `ptr` to 0; no `REQ_DONE` is produced.
  - After release, requester 3 alone is granted normally.

Source files
------------

// File: rtl/axilm_pkg.sv
// Shared types for the AXI4-Lite write arbiter: FSM state encoding, BRESP codes, wrap helper.
// Pure declarations; no timing or flow control of its own.
package axilm_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_RESP  = 3'd2,
    RESP       = 3'd3,
    LOCAL_DONE = 3'd4
  } arb_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/axilm_wr_arb_if.sv
// Requester side, channel-block side and B-channel monitor taps of the write arbiter.
// master = arbiter view, slave = view of the requesters plus channel block around it.
interface axilm_wr_arb_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]    REQ_VALID;
  logic [4*N_REQ-1:0]  REQ_WSTB;
  logic [32*N_REQ-1:0] REQ_ADDR;
  logic [32*N_REQ-1:0] REQ_WDATA;
  logic [N_REQ-1:0]    REQ_READY;
  logic [N_REQ-1:0]    REQ_DONE;
  logic [1:0]          REQ_BRESP;
  logic                BUSY;
  logic                USR_ENA;
  logic [3:0]          USR_WSTB;
  logic [31:0]         USR_ADDR;
  logic [31:0]         USR_WDATA;
  logic [1:0]          USR_BRESP;
  logic                BVALID;
  logic                BREADY;

  modport master (
    input  REQ_VALID, REQ_WSTB, REQ_ADDR, REQ_WDATA, USR_BRESP, BVALID, BREADY,
    output REQ_READY, REQ_DONE, REQ_BRESP, BUSY, USR_ENA, USR_WSTB, USR_ADDR, USR_WDATA
  );

  modport slave (
    output REQ_VALID, REQ_WSTB, REQ_ADDR, REQ_WDATA, USR_BRESP, BVALID, BREADY,
    input  REQ_READY, REQ_DONE, REQ_BRESP, BUSY, USR_ENA, USR_WSTB, USR_ADDR, USR_WDATA
  );

endinterface

// File: rtl/axilm_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping modulo N.
// Zero latency; no state, the caller owns and advances ptr.
module rr_pick
  import axilm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[rr_wrap(int'(ptr), k, N)]) begin
        any = 1'b1;
        idx = IW'(rr_wrap(int'(ptr), k, N));
        gnt[rr_wrap(int'(ptr), k, N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axilm_wr_arb.sv
// Round-robin arbiter sharing one AXI4-Lite write channel block; one write outstanding, DONE 4 cycles after grant at best.
// Requesters hold REQ_VALID until REQ_READY; grants only in IDLE, so everything else waits while BUSY.
module axilm_wr_arb
  import axilm_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic           ACLK,
  input  logic           ARESET,
  axilm_wr_arb_if.master bus
);

  localparam int PW = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    gnt_q, gnt_d;
  logic [PW-1:0]    ptr_nxt;
  logic [3:0]       wstb_q, wstb_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       bresp_q, bresp_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic [3:0]       sel_wstb;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [N_REQ-1:0] gnt_oh;
  logic [N_REQ-1:0] ready;
  logic [N_REQ-1:0] done;
  logic [1:0]       bresp_out;
  logic             ena;

  rr_pick #(.N(N_REQ)) u_pick (
    .req (bus.REQ_VALID),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sel_wstb  = bus.REQ_WSTB[4*int'(pick_idx) +: 4];
  assign sel_addr  = bus.REQ_ADDR[32*int'(pick_idx) +: 32];
  assign sel_wdata = bus.REQ_WDATA[32*int'(pick_idx) +: 32];
  assign gnt_oh    = N_REQ'(1) << gnt_q;
  assign ptr_nxt   = (gnt_q == PW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    wstb_d    = wstb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bresp_d   = bresp_q;
    ready     = '0;
    done      = '0;
    bresp_out = bresp_q;
    ena       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          ready   = pick_gnt;
          gnt_d   = pick_idx;
          wstb_d  = sel_wstb;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          // The channel block drops all-zero-strobe writes, so complete those locally.
          state_d = (sel_wstb != 4'h0) ? ISSUE : LOCAL_DONE;
        end
      end
      ISSUE: begin
        ena     = 1'b1;
        state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (bus.BVALID && bus.BREADY) state_d = RESP;
      end
      RESP: begin
        done      = gnt_oh;
        bresp_out = bus.USR_BRESP;
        bresp_d   = bus.USR_BRESP;
        ptr_d     = ptr_nxt;
        state_d   = IDLE;
      end
      LOCAL_DONE: begin
        done      = gnt_oh;
        bresp_out = OKAY;
        bresp_d   = OKAY;
        ptr_d     = ptr_nxt;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wstb_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      bresp_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wstb_q  <= wstb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bresp_q <= bresp_d;
    end
  end

  assign bus.REQ_READY = ready;
  assign bus.REQ_DONE  = done;
  assign bus.REQ_BRESP = bresp_out;
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.USR_ENA   = ena;
  assign bus.USR_WSTB  = wstb_q;
  assign bus.USR_ADDR  = addr_q;
  assign bus.USR_WDATA = wdata_q;

endmodule

// File: tb/tb_axilm_wr_arb.sv
// Bench for axilm_wr_arb: transaction-timeline model checked every cycle plus directed scenario checks.
module tb_axilm_wr_arb;
  import axilm_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axilm_wr_arb_if #(.N_REQ(N)) ifc ();

  axilm_wr_arb #(.N_REQ(N)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (ifc.master)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Channel-block stand-in: knobs written by the main sequence only.
  int         ch_aw = 0;
  int         ch_b = 0;
  logic [1:0] ch_resp = OKAY;
  int         spur_cnt = 0;

  initial begin : channel
    int cnt;
    int spur_seen;
    spur_seen = 0;
    ifc.BVALID = 1'b0;
    ifc.USR_BRESP = OKAY;
    forever begin
      @(negedge clk);
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        @(posedge clk); #1 ifc.BVALID = 1'b1;
        @(posedge clk); #1 ifc.BVALID = 1'b0;
      end else if (ifc.USR_ENA === 1'b1 && !rst) begin
        cnt = 2 + ch_aw + ch_b;
        while (cnt > 0) begin
          @(posedge clk);
          if (rst) break;
          cnt--;
        end
        if (cnt == 0) begin
          #1 ifc.BVALID = 1'b1;
          @(posedge clk);
          #1 ifc.BVALID = 1'b0;
          ifc.USR_BRESP = ch_resp;
        end
      end
    end
  end

  // Model state: who owns the channel and on which cycle each event is due.
  int          m_ptr, m_owner, m_ena_due, m_done_due;
  logic        m_zero;
  logic [3:0]  m_wstb;
  logic [31:0] m_addr, m_data;
  logic [1:0]  m_bresp;

  int          glog[$];
  int          done_cnt = 0, ena_cnt = 0, busy_gap = 0;
  int          t_ready = 0, t_done = 0;
  logic [N-1:0] done_vec = '0;
  logic [1:0]  done_bresp = '0;
  logic [3:0]  ena_wstb = '0;
  logic [31:0] ena_addr = '0, ena_data = '0;

  initial begin : compare
    int win;
    logic [N-1:0] exp_ready, exp_done;
    logic [1:0]   exp_bresp;
    m_ptr = 0; m_owner = -1; m_ena_due = -1; m_done_due = -1;
    m_zero = 1'b0; m_wstb = '0; m_addr = '0; m_data = '0; m_bresp = OKAY;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_busy",  32'(ifc.BUSY), 0);
        chk("rst_done",  32'(ifc.REQ_DONE), 0);
        chk("rst_ena",   32'(ifc.USR_ENA), 0);
        chk("rst_wstb",  32'(ifc.USR_WSTB), 0);
        chk("rst_addr",  ifc.USR_ADDR, 0);
        chk("rst_wdata", ifc.USR_WDATA, 0);
        chk("rst_bresp", 32'(ifc.REQ_BRESP), 0);
        m_ptr = 0; m_owner = -1; m_ena_due = -1; m_done_due = -1;
        m_wstb = '0; m_addr = '0; m_data = '0; m_bresp = OKAY;
      end else begin
        win = -1;
        if (m_owner < 0)
          for (int k = 0; k < N; k++)
            if (win < 0 && ifc.REQ_VALID[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        exp_done  = '0;
        exp_bresp = m_bresp;
        if (m_owner >= 0 && cyc == m_done_due) begin
          exp_done[m_owner] = 1'b1;
          exp_bresp = m_zero ? OKAY : ifc.USR_BRESP;
        end

        chk("ready",     32'(ifc.REQ_READY), 32'(exp_ready));
        chk("done",      32'(ifc.REQ_DONE), 32'(exp_done));
        chk("bresp",     32'(ifc.REQ_BRESP), 32'(exp_bresp));
        chk("busy",      32'(ifc.BUSY), 32'(m_owner >= 0));
        chk("ena",       32'(ifc.USR_ENA), 32'(cyc == m_ena_due));
        chk("usr_wstb",  32'(ifc.USR_WSTB), 32'(m_wstb));
        chk("usr_addr",  ifc.USR_ADDR, m_addr);
        chk("usr_wdata", ifc.USR_WDATA, m_data);

        for (int i = 0; i < N; i++)
          if (ifc.REQ_READY[i] === 1'b1) begin glog.push_back(i); t_ready = cyc; end
        if (|ifc.REQ_DONE) begin
          done_cnt++; t_done = cyc; done_vec = ifc.REQ_DONE; done_bresp = ifc.REQ_BRESP;
        end
        if (ifc.USR_ENA === 1'b1) begin
          ena_cnt++; ena_wstb = ifc.USR_WSTB; ena_addr = ifc.USR_ADDR; ena_data = ifc.USR_WDATA;
        end
        if (m_owner >= 0 && ifc.BUSY !== 1'b1) busy_gap++;

        if (exp_done != '0) begin
          m_bresp = exp_bresp;
          m_ptr = (m_owner + 1) % N;
          m_owner = -1; m_ena_due = -1; m_done_due = -1;
        end else if (m_owner >= 0 && m_ena_due >= 0 && cyc > m_ena_due && m_done_due < 0 &&
                     ifc.BVALID === 1'b1 && ifc.BREADY === 1'b1) begin
          m_done_due = cyc + 1;
        end
        if (win >= 0) begin
          m_owner = win;
          m_wstb  = ifc.REQ_WSTB[4*win +: 4];
          m_addr  = ifc.REQ_ADDR[32*win +: 32];
          m_data  = ifc.REQ_WDATA[32*win +: 32];
          m_zero  = (m_wstb == 4'h0);
          if (m_zero) m_done_due = cyc + 1;
          else        m_ena_due  = cyc + 1;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ifc.REQ_ADDR[32*i +: 32]  = a;
    ifc.REQ_WDATA[32*i +: 32] = d;
    ifc.REQ_WSTB[4*i +: 4]    = s;
    ifc.REQ_VALID[i]          = 1'b1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int s = glog.size();
    int c = 0;
    while (glog.size() < s + n && c < budget) begin @(posedge clk); c++; end
    chk("grant_timeout", 32'(glog.size() >= s + n), 1);
    #1;
  endtask

  task automatic wait_done_to(input int target, input int budget);
    int c = 0;
    while (done_cnt < target && c < budget) begin @(posedge clk); c++; end
    chk("done_timeout", 32'(done_cnt >= target), 1);
    #1;
  endtask

  function automatic int last_grant();
    return (glog.size() > 0) ? glog[glog.size() - 1] : -1;
  endfunction

  initial begin : main
    int g0, d0, e0, b0;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    ifc.REQ_VALID = '0;
    ifc.REQ_WSTB  = '0;
    ifc.REQ_ADDR  = '0;
    ifc.REQ_WDATA = '0;
    ifc.BREADY    = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 32'(ifc.BUSY), 0);
    chk("idle_usr_addr", ifc.USR_ADDR, 0);

    // All four requesters held high: rotation from ptr 0.
    for (int i = 0; i < N; i++) set_req(i, 32'h100 * (i + 1), 32'hA0 + i, 4'hF);
    g0 = glog.size(); d0 = done_cnt; e0 = ena_cnt;
    wait_grants(5, 200);
    ifc.REQ_VALID = '0;
    wait_done_to(d0 + 5, 50);
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_order%0d", k), (glog.size() > g0 + k) ? glog[g0 + k] : -1, order[k]);
    chk("rr_done_cnt", done_cnt - d0, 5);
    chk("rr_ena_cnt", ena_cnt - e0, 5);

    // Single write from requester 2, immediate slave.
    d0 = done_cnt; e0 = ena_cnt;
    set_req(2, 32'h0000_1000, 32'hDEADBEEF, 4'hF);
    wait_grants(1, 50);
    ifc.REQ_VALID[2] = 1'b0;
    wait_done_to(d0 + 1, 50);
    chk("t1_ena_cnt", ena_cnt - e0, 1);
    chk("t1_addr", ena_addr, 32'h0000_1000);
    chk("t1_data", ena_data, 32'hDEADBEEF);
    chk("t1_wstb", 32'(ena_wstb), 32'hF);
    chk("t1_latency", t_done - t_ready, 4);
    chk("t1_done_vec", 32'(done_vec), 32'b0100);
    chk("t1_bresp", 32'(done_bresp), 0);

    // SLVERR after 5-cycle AW stall and 3-cycle B delay.
    ch_aw = 5; ch_b = 3; ch_resp = SLVERR;
    d0 = done_cnt; b0 = busy_gap;
    set_req(0, 32'h0000_2000, 32'h1234_5678, 4'h3);
    wait_grants(1, 50);
    ifc.REQ_VALID[0] = 1'b0;
    wait_done_to(d0 + 1, 100);
    chk("t2_done_vec", 32'(done_vec), 32'b0001);
    chk("t2_bresp", 32'(done_bresp), 32'(SLVERR));
    chk("t2_latency", t_done - t_ready, 12);
    chk("t2_busy_gap", busy_gap - b0, 0);
    ch_aw = 0; ch_b = 0; ch_resp = OKAY;

    // Zero strobe completes locally one cycle after the grant.
    d0 = done_cnt; e0 = ena_cnt;
    set_req(1, 32'h0000_3000, 32'h0000_CAFE, 4'h0);
    wait_grants(1, 50);
    ifc.REQ_VALID[1] = 1'b0;
    wait_done_to(d0 + 1, 50);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_latency", t_done - t_ready, 1);
    chk("t3_ena_cnt", ena_cnt - e0, 0);
    chk("t3_done_vec", 32'(done_vec), 32'b0010);
    chk("t3_bresp", 32'(done_bresp), 32'(OKAY));

    // A B handshake while idle must be ignored.
    d0 = done_cnt;
    spur_cnt++;
    repeat (6) @(posedge clk);
    #1;
    chk("spur_no_done", done_cnt - d0, 0);
    chk("spur_busy", 32'(ifc.BUSY), 0);

    // Reset during WAIT_RESP aborts the write without a DONE.
    ch_b = 20;
    d0 = done_cnt;
    set_req(3, 32'h0000_4000, 32'h55AA_55AA, 4'hF);
    wait_grants(1, 50);
    ifc.REQ_VALID[3] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(ifc.BUSY), 0);
    chk("mid_rst_addr", ifc.USR_ADDR, 0);
    chk("mid_rst_done", 32'(ifc.REQ_DONE), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ch_b = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt - d0, 0);

    // After reset ptr is 0, so requester 1 wins over 3.
    d0 = done_cnt;
    set_req(1, 32'h0000_5000, 32'h0000_0011, 4'hF);
    set_req(3, 32'h0000_6000, 32'h0000_0033, 4'hC);
    wait_grants(1, 50);
    chk("post_rst_first", last_grant(), 1);
    ifc.REQ_VALID[1] = 1'b0;
    wait_grants(1, 50);
    chk("post_rst_second", last_grant(), 3);
    ifc.REQ_VALID[3] = 1'b0;
    wait_done_to(d0 + 2, 50);

    // Requester 3 alone.
    d0 = done_cnt;
    set_req(3, 32'h0000_7000, 32'h0BAD_F00D, 4'hF);
    wait_grants(1, 50);
    ifc.REQ_VALID[3] = 1'b0;
    wait_done_to(d0 + 1, 50);
    chk("t5_grant", last_grant(), 3);
    chk("t5_done_vec", 32'(done_vec), 32'b1000);
    chk("t5_latency", t_done - t_ready, 4);
    chk("t5_addr", ena_addr, 32'h0000_7000);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
